// File: rtl/sprite_pixel_gen.sv
// Eight-slot sprite shifter: per-slot horizontal countdown, then 2bpp pixel shift-out; lowest active opaque slot wins.
// Output is combinational from held state (zero latency); no backpressure, ce=0 freezes all state.
module sprite_pixel_gen #(
    parameter int NSLOT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic [2:0]  slot,
    input  logic [3:0]  load,
    input  logic [26:0] load_in,
    input  logic        is_spr0,
    input  logic        tick,
    output logic [4:0]  spr_pixel,
    output logic        spr0_win
);

    typedef struct packed {
        logic [7:0] x_cnt;
        logic [7:0] sh1;
        logic [7:0] sh2;
        logic [1:0] pal;
        logic       pri;
        logic       s0;
    } slot_t;

    slot_t slots_q [NSLOT];
    slot_t slots_d [NSLOT];

    // Tick is applied first so that any field strobed by load overrides it.
    always_comb begin
        for (int i = 0; i < NSLOT; i++) begin
            slots_d[i] = slots_q[i];
            if (tick) begin
                if (slots_q[i].x_cnt != 8'd0) begin
                    slots_d[i].x_cnt = slots_q[i].x_cnt - 8'd1;
                end else begin
                    slots_d[i].sh1 = {1'b0, slots_q[i].sh1[7:1]};
                    slots_d[i].sh2 = {1'b0, slots_q[i].sh2[7:1]};
                end
            end
            if (slot == 3'(i)) begin
                if (load[3]) slots_d[i].sh1   = load_in[26:19];
                if (load[2]) slots_d[i].sh2   = load_in[18:11];
                if (load[1]) slots_d[i].x_cnt = load_in[10:3];
                if (load[0]) begin
                    slots_d[i].pal = load_in[2:1];
                    slots_d[i].pri = load_in[0];
                    slots_d[i].s0  = is_spr0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NSLOT; i++) begin
            if (reset) begin
                slots_q[i] <= '0;
            end else if (ce) begin
                slots_q[i] <= slots_d[i];
            end
        end
    end

    // Scan from the highest index down so the lowest qualifying slot is the last writer.
    always_comb begin
        spr_pixel = 5'd0;
        spr0_win  = 1'b0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (slots_q[i].x_cnt == 8'd0 && (slots_q[i].sh1[0] || slots_q[i].sh2[0])) begin
                spr_pixel = {slots_q[i].pri, slots_q[i].pal, slots_q[i].sh2[0], slots_q[i].sh1[0]};
                spr0_win  = slots_q[i].s0;
            end
        end
    end

endmodule

// File: tb/tb_sprite_pixel_gen.sv
// Directed bench for sprite_pixel_gen: stimulus pushes expected {spr_pixel, spr0_win}, a monitor pops and compares.
module tb_sprite_pixel_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b0;
    logic [2:0]  slot = 3'd0;
    logic [3:0]  load = 4'd0;
    logic [26:0] load_in = 27'd0;
    logic        is_spr0 = 1'b0;
    logic        tick = 1'b0;
    logic [4:0]  spr_pixel;
    logic        spr0_win;

    int checks = 0;
    int errors = 0;
    int step_id = 0;

    logic [5:0] exp_q [$];
    int         id_q  [$];

    sprite_pixel_gen #(.NSLOT(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .slot      (slot),
        .load      (load),
        .load_in   (load_in),
        .is_spr0   (is_spr0),
        .tick      (tick),
        .spr_pixel (spr_pixel),
        .spr0_win  (spr0_win)
    );

    always #5 clk = ~clk;

    function automatic logic [26:0] fld(input logic [7:0] p1, input logic [7:0] p2,
                                        input logic [7:0] x, input logic [1:0] pal, input logic pri);
        return {p1, p2, x, pal, pri};
    endfunction

    // Drive one cycle of inputs, let the edge happen, then queue the expected post-edge outputs.
    task automatic cyc(input logic r, input logic c, input logic [2:0] s, input logic [3:0] ld,
                       input logic [26:0] li, input logic s0, input logic tk,
                       input logic [4:0] ep, input logic ew);
        reset   = r;
        ce      = c;
        slot    = s;
        load    = ld;
        load_in = li;
        is_spr0 = s0;
        tick    = tk;
        @(posedge clk);
        #1;
        step_id++;
        exp_q.push_back({ep, ew});
        id_q.push_back(step_id);
        reset   = 1'b0;
        ce      = 1'b1;
        load    = 4'd0;
        tick    = 1'b0;
        is_spr0 = 1'b0;
    endtask

    task automatic tk(input logic [4:0] ep, input logic ew);
        cyc(1'b0, 1'b1, 3'd0, 4'd0, 27'd0, 1'b0, 1'b1, ep, ew);
    endtask

    task automatic ld(input logic [2:0] s, input logic [3:0] l, input logic [26:0] li,
                      input logic s0, input logic [4:0] ep, input logic ew);
        cyc(1'b0, 1'b1, s, l, li, s0, 1'b0, ep, ew);
    endtask

    task automatic rst(input logic c);
        cyc(1'b1, c, 3'd0, 4'd0, 27'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    // Monitor: outputs are always valid, so compare whenever an expectation is pending.
    initial begin
        logic [5:0] e;
        int id;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                id = id_q.pop_front();
                checks++;
                if ({spr_pixel, spr0_win} !== e) begin
                    errors++;
                    $display("FAIL step %0d: got spr_pixel=%b spr0_win=%b, want spr_pixel=%b spr0_win=%b",
                             id, spr_pixel, spr0_win, e[5:1], e[0]);
                end
            end
        end
    end

    initial begin
        int wait_cnt;

        // Reset with ce low still clears everything.
        rst(1'b0);
        rst(1'b0);

        // Slot 2: pix1=0x01, x=3, pal=2, pri=1.
        ld(3'd2, 4'b1111, fld(8'h01, 8'h00, 8'd3, 2'd2, 1'b1), 1'b0, 5'd0, 1'b0);
        tk(5'd0, 1'b0);
        tk(5'd0, 1'b0);
        tk(5'b11001, 1'b0);
        tk(5'd0, 1'b0);
        rst(1'b1);

        // Priority between slots 1 and 4.
        ld(3'd1, 4'b1111, fld(8'hFF, 8'h00, 8'd0, 2'd1, 1'b0), 1'b0, 5'b00101, 1'b0);
        ld(3'd4, 4'b1111, fld(8'hFF, 8'hFF, 8'd0, 2'd3, 1'b1), 1'b0, 5'b00101, 1'b0);
        ld(3'd1, 4'b1000, fld(8'h00, 8'h00, 8'd0, 2'd0, 1'b0), 1'b0, 5'b11111, 1'b0);
        tk(5'b11111, 1'b0);
        rst(1'b1);

        // Sprite-0 flag lasts 8 pixels, then x stays at 0 for 20 ticks.
        ld(3'd0, 4'b1111, fld(8'hFF, 8'h00, 8'd0, 2'd0, 1'b0), 1'b1, 5'b00001, 1'b1);
        for (int i = 1; i <= 20; i++) begin
            if (i < 8) tk(5'b00001, 1'b1);
            else       tk(5'd0, 1'b0);
        end
        ld(3'd0, 4'b1000, fld(8'hFF, 8'h00, 8'd0, 2'd0, 1'b0), 1'b0, 5'b00001, 1'b1);
        ld(3'd0, 4'b1111, fld(8'hFF, 8'h00, 8'd0, 2'd0, 1'b0), 1'b0, 5'b00001, 1'b0);
        tk(5'b00001, 1'b0);
        tk(5'b00001, 1'b0);
        rst(1'b1);

        // Load-with-tick on slot 3 while slot 6 counts down; ce=0 freezes.
        ld(3'd6, 4'b1111, fld(8'hFF, 8'h00, 8'd1, 2'd2, 1'b0), 1'b0, 5'd0, 1'b0);
        cyc(1'b0, 1'b1, 3'd3, 4'b1111, fld(8'hFF, 8'h00, 8'd5, 2'd1, 1'b0), 1'b0, 1'b1, 5'b01001, 1'b0);
        cyc(1'b0, 1'b0, 3'd3, 4'b1111, fld(8'hFF, 8'h00, 8'd0, 2'd1, 1'b0), 1'b1, 1'b1, 5'b01001, 1'b0);
        cyc(1'b0, 1'b0, 3'd0, 4'd0, 27'd0, 1'b0, 1'b1, 5'b01001, 1'b0);
        for (int i = 1; i <= 4; i++) tk(5'b01001, 1'b0);
        tk(5'b00101, 1'b0);

        // Reset mid-line with an opaque sprite 0 winning, and with load/tick asserted.
        ld(3'd0, 4'b1111, fld(8'hFF, 8'h00, 8'd0, 2'd0, 1'b0), 1'b1, 5'b00001, 1'b1);
        cyc(1'b1, 1'b1, 3'd5, 4'b1111, fld(8'hFF, 8'hFF, 8'd0, 2'd3, 1'b1), 1'b1, 1'b1, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) tk(5'd0, 1'b0);

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations still pending, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_pixel_gen.md
SPRITE_PIXEL_GEN -- requirements
Module: sprite_pixel_gen

Interface
REQ-001 SHALL have parameter NSLOT, default 8, meaning number of sprite slots; only 8 is supported.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port ce  input  1  clock enable; when 0, no state changes.
REQ-005 SHALL have port slot  input  3  index of the slot that receives load/load_in this cycle.
REQ-006 SHALL have port load  input  4  field strobes: {pix1, pix2, x, attr} = load[3:0].
REQ-007 SHALL have port load_in  input  27  {pix1[7:0], pix2[7:0], x[7:0], palette[1:0], priority} = [26:19], [18:11], [10:3], [2:1], [0].
REQ-008 SHALL have port is_spr0  input  1  the sprite being loaded is OAM entry 0; sampled with load[0].
REQ-009 SHALL have port tick  input  1  advance one pixel (visible-area dot).
REQ-010 SHALL have port spr_pixel  output  5  {priority, palette[1:0], pix[1:0]} of the winning slot; 0 if none.
REQ-011 SHALL have port spr0_win  output  1  the winning opaque pixel comes from a slot flagged is_spr0.

Function
REQ-012 Each slot SHALL hold x_cnt[7:0], sh1[7:0], sh2[7:0], pal[1:0], pri, s0 flag.
REQ-013 Loads: with ce=1, load[3] writes sh1, load[2] writes sh2, load[1] writes x_cnt, load[0] writes {pal, pri, s0}, all only in the slot addressed by slot.
REQ-014 Several load bits in one cycle SHALL all take effect in the addressed slot.
REQ-015 Tick: with ce=1 and tick=1, each slot with x_cnt != 0 SHALL decrement x_cnt by 1; each slot with x_cnt == 0 SHALL shift sh1 and sh2 right one bit, with 0 shifted into bit 7.
REQ-016 A slot is active when x_cnt == 0; its pixel is {sh2[0], sh1[0]}.
REQ-017 x_cnt SHALL saturate at 0 and never wrap to 255.
REQ-018 After 8 shifts, sh1 and sh2 are 0 and the slot is transparent until reloaded.
REQ-019 Load and tick in the same cycle: the addressed slot's loaded fields SHALL take the load_in value (load wins); unloaded fields and other slots SHALL tick normally.
REQ-020 spr_pixel SHALL be combinational from current state, with zero latency: the lowest-index active slot with nonzero pixel wins and drives {pri, pal, pix}; spr_pixel = 0 if no slot qualifies.
REQ-021 spr0_win SHALL be the s0 flag of the winning slot, and 0 when there is no winner.
REQ-022 ce=0 SHALL freeze all state regardless of load and tick; outputs still reflect held state.
REQ-023 load, slot, tick and is_spr0 SHALL be don't-care when ce=0.

Reset
REQ-024 reset=1 at a clk edge SHALL clear every slot's x_cnt, sh1, sh2, pal, pri and s0 to 0, independent of ce.
REQ-025 Reset SHALL take priority over simultaneous load or tick.
REQ-026 During and after reset, spr_pixel = 0 and spr0_win = 0 until a slot is loaded with nonzero pixels.
REQ-027 Reset asserted mid-line SHALL abort all shifting; no stale pixel SHALL appear afterwards.

Verification
REQ-028 Load slot 2: pix1=0x01, pix2=0x00, x=3, pal=2, pri=1 -> spr_pixel=0 for 3 ticks; after the 3rd tick spr_pixel=5'b11001; after 1 more tick spr_pixel=0.
REQ-029 Slots 1 and 4 both x=0, opaque, with different palettes -> spr_pixel shows slot 1; with slot 1 pixel bits 0 and slot 4 opaque -> shows slot 4.
REQ-030 Slot 0 loaded with is_spr0=1, x=0, pix1=0xFF -> spr0_win=1 for 8 ticks, then 0; with is_spr0=0 -> spr0_win=0 throughout.
REQ-031 x=0 slot ticked 20 times -> x_cnt stays 0 and pixels are 0 after tick 8; no wrap.
REQ-032 Load x=5 into slot 3 in the same cycle as tick, with slot 6 at x=1 -> slot 3 x_cnt=5, slot 6 x_cnt=0; ce=0 with tick held -> no change.
REQ-033 Reset mid-line with opaque pixels active -> next cycle spr_pixel=0 and spr0_win=0; reset with load asserted -> slot stays 0.
